// File: rtl/dac_seg_encoder.sv
// Segmented current-steering DAC front end: input stream FIFO, sample-rate pacing,
// binary/thermometer split with data-weighted-averaging rotation of the MSB elements.
module dac_seg_encoder #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PRIME_LVL = 2
) (
  input  logic        clkin,
  input  logic        rstb,
  input  logic        en,
  input  logic        dwa_en,
  input  logic [9:0]  code_in,
  input  logic        code_valid,
  output logic        code_ready,
  output logic        sample_stb,
  output logic [6:0]  datainbin,
  output logic [6:0]  datainbinb,
  output logic [16:0] dataintherm,
  output logic [16:0] datainthermb,
  output logic [4:0]  dwa_ptr,
  output logic [2:0]  fifo_level,
  output logic [7:0]  uflow_cnt
);

  localparam int unsigned CW = 10;
  localparam int unsigned BW = 7;
  localparam int unsigned TW = 17;
  localparam int unsigned PW = 5;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned DW = $clog2(DIV);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [DW-1:0]   div_cnt;
  logic [DW-1:0]   div_next;
  logic            upd;
  logic            flush;

  logic [CW-1:0]   mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [LW-1:0]   level;
  logic [LW-1:0]   level_next;
  logic            ready_next;
  logic            push;
  logic            pop;

  logic [CW-1:0]   held;
  logic [CW-1:0]   src;
  logic [2:0]      n_seg;
  logic [5:0]      off;
  logic [TW-1:0]   therm_enc;
  logic [PW-1:0]   ptr_sum;
  logic [PW-1:0]   ptr_next;

  assign fifo_level = 3'(level);

  // Sequencing: wait for enable, prime the FIFO, then pace updates with the divider.
  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    upd        = 1'b0;
    flush      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_next = ST_PRIME;
      end
      ST_PRIME: begin
        div_next = '0;
        if (level >= LW'(PRIME_LVL)) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (div_cnt == DW'(DIV - 1)) begin
          div_next = '0;
          upd      = 1'b1;
        end else begin
          div_next = div_cnt + DW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (!en) begin
      state_next = ST_IDLE;
      div_next   = '0;
      upd        = 1'b0;
      flush      = 1'b1;
    end
  end

  always_ff @(posedge clkin or negedge rstb) begin
    if (!rstb) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Encoder: element i is lit when its distance from the pointer (mod 17) is below N.
  always_comb begin
    push      = code_valid && code_ready && !flush;
    pop       = upd && (level != '0);
    src       = pop ? mem[rd_ptr] : held;
    n_seg     = src[CW-1:BW];
    off       = '0;
    therm_enc = '0;
    for (int i = 0; i < TW; i++) begin
      off = 6'(i) + 6'(TW) - {1'b0, dwa_ptr};
      if (off >= 6'(TW)) off = off - 6'(TW);
      therm_enc[i] = (off < {3'b000, n_seg});
    end
    ptr_sum = dwa_ptr + PW'(n_seg);
    if (ptr_sum >= PW'(TW)) ptr_sum = ptr_sum - PW'(TW);
    ptr_next = dwa_en ? ptr_sum : '0;

    level_next = level;
    if (flush)              level_next = '0;
    else if (push && !pop)  level_next = level + LW'(1);
    else if (pop && !push)  level_next = level - LW'(1);
    ready_next = (state_next != ST_IDLE) && (level_next < LW'(DEPTH));
  end

  always_ff @(posedge clkin or negedge rstb) begin
    if (!rstb) begin
      div_cnt      <= '0;
      level        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      code_ready   <= 1'b0;
      sample_stb   <= 1'b0;
      held         <= '0;
      datainbin    <= '0;
      datainbinb   <= '1;
      dataintherm  <= '0;
      datainthermb <= '1;
      dwa_ptr      <= '0;
      uflow_cnt    <= '0;
    end else begin
      div_cnt    <= div_next;
      level      <= level_next;
      code_ready <= ready_next;
      sample_stb <= upd;
      if (flush) begin
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        held         <= '0;
        datainbin    <= '0;
        datainbinb   <= '1;
        dataintherm  <= '0;
        datainthermb <= '1;
        dwa_ptr      <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (upd) begin
          held         <= src;
          datainbin    <= src[BW-1:0];
          datainbinb   <= ~src[BW-1:0];
          dataintherm  <= therm_enc;
          datainthermb <= ~therm_enc;
          dwa_ptr      <= ptr_next;
          if (!pop && (uflow_cnt != '1)) uflow_cnt <= uflow_cnt + 8'd1;
        end
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by level and pointers.
  always_ff @(posedge clkin) begin
    if (push) mem[wr_ptr] <= code_in;
  end

endmodule

// File: tb/tb_dac_seg_encoder.sv
// Scoreboard bench for dac_seg_encoder: accepted codes queue up as expected samples,
// and a negedge monitor checks every strobed output against a plain-arithmetic model.
module tb_dac_seg_encoder;

  localparam int DIV       = 4;
  localparam int DEPTH     = 4;
  localparam int PRIME_LVL = 2;

  logic        clkin = 1'b0;
  logic        rstb = 1'b0;
  logic        en = 1'b0;
  logic        dwa_en = 1'b0;
  logic [9:0]  code_in = '0;
  logic        code_valid = 1'b0;
  logic        code_ready;
  logic        sample_stb;
  logic [6:0]  datainbin;
  logic [6:0]  datainbinb;
  logic [16:0] dataintherm;
  logic [16:0] datainthermb;
  logic [4:0]  dwa_ptr;
  logic [2:0]  fifo_level;
  logic [7:0]  uflow_cnt;

  dac_seg_encoder #(.DIV(DIV), .DEPTH(DEPTH), .PRIME_LVL(PRIME_LVL)) dut (
    .clkin(clkin), .rstb(rstb), .en(en), .dwa_en(dwa_en),
    .code_in(code_in), .code_valid(code_valid), .code_ready(code_ready),
    .sample_stb(sample_stb), .datainbin(datainbin), .datainbinb(datainbinb),
    .dataintherm(dataintherm), .datainthermb(datainthermb),
    .dwa_ptr(dwa_ptr), .fifo_level(fifo_level), .uflow_cnt(uflow_cnt)
  );

  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [9:0]  exp_q[$];
  int          m_ptr = 0;
  logic [9:0]  m_held = '0;
  int          m_uflow = 0;
  bit          p_push = 0;
  logic [9:0]  p_code = '0;
  bit          p_en = 0;
  bit          p_dwa = 0;
  int          cyc = 0;
  int          stb_count = 0;
  int          prev_stb = 0;
  bit          prev_ok = 0;
  bit          seen_full = 0;
  logic [9:0]  mc;
  int          mn;
  logic [6:0]  mb;
  logic [6:0]  mb_n;
  logic [16:0] mt;
  logic [16:0] mt_n;

  function automatic logic [16:0] therm_of(input int ptr, input int n);
    logic [16:0] t;
    t = '0;
    for (int k = 0; k < n; k++) t[(ptr + k) % 17] = 1'b1;
    return t;
  endfunction

  // Monitor: strobe check, then commit the push/flush of the edge just passed, then sample inputs.
  initial begin : monitor
    forever begin
      @(negedge clkin);
      cyc++;
      if (!rstb) begin
        chk("rst_bin", datainbin, 0);
        chk("rst_binb", datainbinb, 7'h7F);
        chk("rst_therm", dataintherm, 0);
        chk("rst_thermb", datainthermb, 17'h1FFFF);
        chk("rst_ptr", dwa_ptr, 0);
        chk("rst_ready", code_ready, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_uflow", uflow_cnt, 0);
        chk("rst_stb", sample_stb, 0);
        exp_q.delete();
        m_ptr = 0; m_held = '0; m_uflow = 0;
        p_push = 0; p_en = 0; p_dwa = 0; prev_ok = 0;
        continue;
      end
      if (sample_stb) begin
        stb_count++;
        chk("stb_while_enabled", p_en, 1);
        if (prev_ok) chk("stb_gap", cyc - prev_stb, DIV);
        prev_stb = cyc;
        prev_ok  = 1;
        if (exp_q.size() > 0) begin
          mc = exp_q.pop_front();
        end else begin
          mc = m_held;
          if (m_uflow < 255) m_uflow++;
        end
        m_held = mc;
        mn   = int'(mc) / 128;
        mb   = 7'(int'(mc) % 128);
        mb_n = ~mb;
        mt   = therm_of(m_ptr, mn);
        mt_n = ~mt;
        m_ptr = p_dwa ? (m_ptr + mn) % 17 : 0;
        chk("sb_bin", datainbin, mb);
        chk("sb_binb", datainbinb, mb_n);
        chk("sb_therm", dataintherm, mt);
        chk("sb_thermb", datainthermb, mt_n);
        chk("sb_ptr", dwa_ptr, m_ptr);
        chk("sb_uflow", uflow_cnt, m_uflow);
      end
      if (p_push) exp_q.push_back(p_code);
      if (!p_en) begin
        exp_q.delete();
        m_ptr = 0; m_held = '0; prev_ok = 0;
        chk("idle_bin", datainbin, 0);
        chk("idle_therm", dataintherm, 0);
        chk("idle_thermb", datainthermb, 17'h1FFFF);
        chk("idle_ptr", dwa_ptr, 0);
        chk("idle_stb", sample_stb, 0);
      end
      chk("level", fifo_level, exp_q.size());
      chk("ready", code_ready, (p_en && (exp_q.size() < DEPTH)));
      if ((fifo_level == 3'(DEPTH)) && !code_ready) seen_full = 1;
      p_en   = en;
      p_dwa  = dwa_en;
      p_push = en && code_valid && code_ready;
      p_code = code_in;
    end
  end

  task automatic sync();
    @(posedge clkin);
    #1;
  endtask

  task automatic push_code(input logic [9:0] c);
    int n = 0;
    code_in    = c;
    code_valid = 1'b1;
    @(negedge clkin);
    while (!code_ready && n < 100) begin
      @(negedge clkin);
      n++;
    end
    chk("push_accept", code_ready, 1);
    @(posedge clkin);
    #1;
    code_valid = 1'b0;
  endtask

  task automatic wait_stb(input int target, input int bound, input string name);
    int n = 0;
    while (stb_count < target && n < bound) begin
      @(negedge clkin);
      #1;
      n++;
    end
    chk(name, (stb_count >= target), 1);
  endtask

  int base;
  int nd;

  initial begin : main
    rstb = 1'b0;
    repeat (3) sync();
    rstb = 1'b1;

    // Static encode, no rotation
    sync();
    en = 1'b1; dwa_en = 1'b0;
    base = stb_count;
    push_code(10'd1023);
    push_code(10'd1023);
    wait_stb(base + 1, 40, "static_first");
    chk("static_bin", datainbin, 127);
    chk("static_binb", datainbinb, 0);
    chk("static_therm", dataintherm, 17'h0007F);
    chk("static_thermb", datainthermb, 17'h1FF80);
    chk("static_ptr", dwa_ptr, 0);
    wait_stb(base + 2, 20, "static_second");
    chk("static_therm2", dataintherm, 17'h0007F);
    chk("static_ptr2", dwa_ptr, 0);

    // DWA rotation
    sync(); en = 1'b0;
    sync(); en = 1'b1; dwa_en = 1'b1;
    base = stb_count;
    repeat (3) push_code(10'd384);
    wait_stb(base + 1, 40, "dwa_first");
    chk("dwa_therm1", dataintherm, 17'h00007);
    chk("dwa_ptr1", dwa_ptr, 3);
    wait_stb(base + 2, 20, "dwa_second");
    chk("dwa_therm2", dataintherm, 17'h00038);
    chk("dwa_ptr2", dwa_ptr, 6);
    wait_stb(base + 3, 20, "dwa_third");
    chk("dwa_therm3", dataintherm, 17'h001C0);
    chk("dwa_ptr3", dwa_ptr, 9);

    // Pointer wrap across element 16
    sync(); en = 1'b0;
    sync(); en = 1'b1;
    base = stb_count;
    repeat (5) push_code(10'd384);
    push_code(10'd0);
    push_code(10'd512);
    wait_stb(base + 7, 80, "wrap_reached");
    chk("wrap_therm", dataintherm, 17'h18003);
    chk("wrap_ptr", dwa_ptr, 2);

    // Underflow: one code, then starve the FIFO
    sync();
    push_code(10'd300);
    base = stb_count;
    wait_stb(base + 1, 20, "uf_pop");
    chk("uf_bin", datainbin, 44);
    chk("uf_ones", $countones(dataintherm), 2);
    wait_stb(base + 2, 20, "uf_hold");
    chk("uf_hold_bin", datainbin, 44);
    chk("uf_hold_ones", $countones(dataintherm), 2);
    wait_stb(base + 301, 1300, "uf_long");
    chk("uf_saturate", uflow_cnt, 255);

    // Back-pressure: valid held high over random codes
    sync();
    seen_full = 0;
    for (int i = 0; i < 12; i++) push_code(10'($urandom_range(0, 1023)));
    chk("bp_full_seen", seen_full, 1);
    nd = 0;
    while (exp_q.size() != 0 && nd < 200) begin
      @(negedge clkin);
      #1;
      nd++;
    end
    chk("bp_drained", exp_q.size(), 0);

    // Drop enable mid-run
    sync(); en = 1'b0;
    sync();
    chk("off_level", fifo_level, 0);
    chk("off_bin", datainbin, 0);
    chk("off_therm", dataintherm, 0);
    chk("off_ptr", dwa_ptr, 0);
    chk("off_ready", code_ready, 0);

    // Re-enable: PRIME holds until two codes are buffered
    en = 1'b1;
    base = stb_count;
    push_code(10'($urandom_range(0, 1023)));
    repeat (12) sync();
    chk("prime_no_stb", stb_count - base, 0);
    chk("prime_level", fifo_level, 1);
    push_code(10'($urandom_range(0, 1023)));
    wait_stb(base + 1, 20, "prime_to_run");

    // Random traffic with occasional enable drops and DWA toggles
    for (int i = 0; i < 400; i++) begin
      sync();
      code_valid = 1'($urandom_range(0, 1));
      code_in    = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 15) == 0) dwa_en = ~dwa_en;
      en = ($urandom_range(0, 59) != 0);
    end
    sync();
    code_valid = 1'b0;
    en = 1'b1;

    // Asynchronous reset while running
    push_code(10'($urandom_range(0, 1023)));
    push_code(10'($urandom_range(0, 1023)));
    wait_stb(stb_count + 1, 40, "pre_reset_run");
    sync();
    rstb = 1'b0;
    #1;
    chk("arst_bin", datainbin, 0);
    chk("arst_binb", datainbinb, 7'h7F);
    chk("arst_therm", dataintherm, 0);
    chk("arst_thermb", datainthermb, 17'h1FFFF);
    chk("arst_ptr", dwa_ptr, 0);
    chk("arst_ready", code_ready, 0);
    chk("arst_uflow", uflow_cnt, 0);
    repeat (2) sync();
    rstb = 1'b1;
    repeat (4) sync();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dac_seg_encoder.md
Name: dac_seg_encoder

Overview:
Digital front end that drives the segmented current-steering DAC core. It does the following:
- Accepts 10-bit sample codes over a valid/ready stream and buffers them in a small FIFO.
- Releases one code per sample period (clkin divided by DIV).
- Encodes each code into a 7-bit binary LSB segment and a 17-element thermometer MSB segment, with data-weighted-averaging (DWA) rotation of the thermometer elements.
- Drives the true and complement data buses of the DAC core from registered outputs.

Parameters:
DIV, 4, clkin cycles per sample period (≥2)
DEPTH, 4, input FIFO depth (power of 2, ≥2)
PRIME_LVL, 2, FIFO level required to leave PRIME (1..DEPTH)

Ports:
clkin  input  1  clock; all state on rising edge
rstb  input  1  asynchronous active-low reset
en  input  1  run enable
dwa_en  input  1  1 = rotate thermometer pointer; 0 = pointer fixed at 0
code_in  input  10  unsigned sample code
code_valid  input  1  code_in valid
code_ready  output  1  FIFO can accept code
sample_stb  output  1  one-cycle pulse on each output update
datainbin  output  7  binary segment, bit i weight 2^i
datainbinb  output  7  bitwise complement of datainbin
dataintherm  output  17  thermometer elements, each weight 128
datainthermb  output  17  bitwise complement of dataintherm
dwa_ptr  output  5  current DWA start pointer, 0..16
fifo_level  output  3  FIFO occupancy, 0..DEPTH
uflow_cnt  output  8  saturating underflow counter

Behaviour:
- Clock and reset: one clock (clkin); reset is asynchronous and active-low (rstb).
- Reset values:
  - datainbin=0, dataintherm=0, datainbinb=all 1s, datainthermb=all 1s.
  - dwa_ptr=0, fifo_level=0, uflow_cnt=0, sample_stb=0.
  - code_ready=0, state=IDLE, divider=0, held code=0.
- Complement outputs come from their own flops, loaded on the same edge as the true outputs. They are never combinational inverters.
- Encoding of code c:
  - N = c[9:7], range 0..7.
  - Binary segment = c[6:0].
  - Thermometer elements (ptr+k) mod 17 for k=0..N-1 are 1; all others are 0.
  - Exactly N ones appear in dataintherm.
  - Next ptr = (ptr+N) mod 17 if dwa_en=1, else 0.
- FSM states:
  - IDLE:
    - code_ready=0; FIFO empty.
    - Outputs forced to code 0 (true=0, complement=1), ptr=0.
    - Goes to PRIME when en=1.
  - PRIME:
    - code_ready = (level<DEPTH); divider held at 0.
    - Goes to RUN when level ≥ PRIME_LVL.
  - RUN:
    - Divider counts 0..DIV-1 and wraps.
    - The edge where divider==DIV-1 is the update edge.
  - From any state, en=0 → IDLE on the next edge: flush FIFO, force outputs to code 0, ptr=0. uflow_cnt is kept.
- Update edge:
  - If FIFO is non-empty: pop the head, encode it, load outputs, update ptr.
  - If FIFO is empty (underflow): re-encode the held code. The held code is the last popped code, or 0 if none has been popped since IDLE. ptr advances as normal. uflow_cnt increments and saturates at 255.
  - sample_stb is high for the cycle following each update edge, coincident with the new output values.
- Input push and FIFO rules:
  - A push occurs when code_valid && code_ready.
  - code_ready = (state≠IDLE) && (level<DEPTH). It is registered from state/level and has no combinational path from code_valid.
  - Push and pop on the same edge: level unchanged, order preserved.
  - A push while full is impossible because ready=0.
- Latency: a code pushed into an empty FIFO in RUN appears on the outputs after the next update edge (at most DIV cycles).
- Reset mid-operation clears everything immediately to the reset values, including uflow_cnt.

Test Plan:
- Reset: assert rstb=0 mid-RUN → same cycle: datainbin=0, datainbinb=7'h7F, dataintherm=0, datainthermb=17'h1FFFF, dwa_ptr=0, code_ready=0.
- Static encode: dwa_en=0, push 1023, 1023 → after first update: bin=127, therm=17'h0007F, complements exact inverses, ptr stays 0; sample_stb pulses once every DIV=4 cycles.
- DWA rotation: dwa_en=1, codes 384,384,384 → therm=0x00007, 0x00038, 0x001C0; ptr 0→3→6→9.
- Wrap: preload ptr to 15 via five updates of code 384 then code 0 (ptr=15), push 512 → therm bits 15,16,0,1 set, ptr=2.
- Underflow: push one code 300 in RUN, stop pushing → next update holds bin=44, therm N=2; uflow_cnt increments per update; after 300 empty updates uflow_cnt=255.
- Back-pressure and enable: hold code_valid=1 with DEPTH=4 → code_ready=0 at level 4, in-order output, no loss. Drop en mid-RUN → IDLE next edge, fifo_level=0, outputs code 0, ptr=0. Re-enable → PRIME until level 2, then RUN.
